addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_seq.sv | 104 ++++++++++
 tb/tb_addsub_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - chunk-serial two's complement adder/subtractor with valid/ready handshake
// Optional clamping of overflowed results is enabled by defining ADDSUB_SATURATE_EN.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             of,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] xr, yr;
  logic [WIDTH-1:0] s_next, s_fin;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [CHUNK:0]   sum;
  logic             last, accept, of_fin;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = BUSY;
      BUSY:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // One CHUNK-wide slice per cycle; yr already holds ~y for subtraction, carry-in supplies the +1.
  always_comb begin
    sum = {1'b0, xr[cnt*CHUNK +: CHUNK]} + {1'b0, yr[cnt*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, carry};
    s_next = s;
    s_next[cnt*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    of_fin = (xr[WIDTH-1] == yr[WIDTH-1]) && (s_next[WIDTH-1] != xr[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    if (of_fin)
      s_fin = xr[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      s_fin = s_next;
`else
    s_fin = s_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr    <= '0;
      yr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      of    <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      xr    <= x;
      yr    <= y ^ {WIDTH{m}};
      carry <= m;
      cnt   <= '0;
    end else if (state == BUSY) begin
      carry <= sum[CHUNK];
      cnt   <= cnt + CW'(1);
      if (last) begin
        s    <= s_fin;
        cout <= sum[CHUNK];
        of   <= of_fin;
        zero <= (s_fin == '0);
      end else begin
        s    <= s_next;
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - randomized self-checking bench for addsub_seq against an arithmetic model
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0, out_ready = 1'b0, m = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic        in_ready, out_valid, cout, of, zero;
  logic [31:0] s;

  logic        h_in_valid = 1'b0, h_out_ready = 1'b0, h_m = 1'b0;
  logic [15:0] h_x = '0, h_y = '0;
  logic        h_in_ready, h_out_valid, h_cout, h_of, h_zero;
  logic [15:0] h_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .m(m), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .of(of), .zero(zero)
  );

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .x(h_x), .y(h_y), .m(h_m), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .s(h_s), .cout(h_cout), .of(h_of), .zero(h_zero)
  );

  // Reference: exact signed/unsigned integer arithmetic, then wrap or clamp.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic md,
                                output logic [31:0] rs, output logic rc, output logic ro,
                                output logic rz);
    longint sa, sb, r;
    longint ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = md ? sa - sb : sa + sb;
    rc = md ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
    ro = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    rs = r[31:0];
`ifdef ADDSUB_SATURATE_EN
    if (ro) rs = r[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    rz = (rs == 32'd0);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic md,
                        output logic [31:0] rs, output logic rc, output logic ro,
                        output logic rz, output int lat, output logic acc);
    acc = in_ready;
    in_valid = 1'b1; x = a; y = b; m = md;
    @(posedge clk); #1;
    in_valid = 1'b0; x = $urandom; y = $urandom; m = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s; rc = cout; ro = of; rz = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, s, cout, of, zero} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b s=%h c=%b o=%b z=%b want rdy=1 vld=0 s=0 flags=0",
               in_ready, out_valid, s, cout, of, zero);
    end
    checks++;
    if ({h_in_ready, h_out_valid, h_s} !== {1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_state16 got rdy=%b vld=%b s=%h want 1 0 0", h_in_ready, h_out_valid, h_s);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] ta[6], tb[6], es[6];
    logic        tm[6], ec[6], eo[6], ez[6];
    logic [31:0] rs; logic rc, ro, rz, acc; int lat;
    ta = '{32'h2, 32'h7FFF_FFFF, 32'h2, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};
    tb = '{32'h3, 32'h7FFF_FFFF, 32'h2, 32'h2, 32'h1,         32'h1};
    tm = '{1'b0,  1'b0,          1'b1,  1'b1,  1'b1,          1'b0};
`ifdef ADDSUB_SATURATE_EN
    es = '{32'h5, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
`else
    es = '{32'h5, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0};
`endif
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    eo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ez = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tm[i], rs, rc, ro, rz, lat, acc);
      checks++;
      if ({acc, rs, rc, ro, rz} !== {1'b1, es[i], ec[i], eo[i], ez[i]}) begin
        failures++;
        $display("FAIL directed_%0d got acc=%b s=%h c=%b o=%b z=%b want acc=1 s=%h c=%b o=%b z=%b",
                 i, acc, rs, rc, ro, rz, es[i], ec[i], eo[i], ez[i]);
      end
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL directed_latency_%0d got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, rs, es; logic md, rc, ro, rz, ec, eo, ez, acc; int lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; md = 1'($urandom_range(0, 1));
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) a = {1'b0, a[30:0]} | 32'h7F00_0000;
      model(a, b, md, es, ec, eo, ez);
      run_op(a, b, md, rs, rc, ro, rz, lat, acc);
      checks++;
      if ({acc, rs, rc, ro, rz, lat} !== {1'b1, es, ec, eo, ez, 32'd4}) begin
        failures++;
        $display("FAIL random_%0d x=%h y=%h m=%b got s=%h c=%b o=%b z=%b lat=%0d acc=%b want s=%h c=%b o=%b z=%b lat=4",
                 i, a, b, md, rs, rc, ro, rz, lat, acc, es, ec, eo, ez);
      end
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        failures++;
        $display("FAIL random_release_%0d got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] es, es2; logic ec, eo, ez, ec2, eo2, ez2; int lat;
    logic [31:0] a2 = 32'hDEAD_BEEF, b2 = 32'h0BAD_F00D;
    model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, es, ec, eo, ez);
    model(a2, b2, 1'b1, es2, ec2, eo2, ez2);
    in_valid = 1'b1; x = 32'h1234_5678; y = 32'h0F0F_0F0F; m = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      x = $urandom; y = $urandom; m = ~m;
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, s, cout, of, zero} !== {1'b1, 1'b0, es, ec, eo, ez}) begin
        failures++;
        $display("FAIL hold_%0d got vld=%b rdy=%b s=%h c=%b o=%b z=%b want vld=1 rdy=0 s=%h c=%b o=%b z=%b",
                 i, out_valid, in_ready, s, cout, of, zero, es, ec, eo, ez);
      end
      x = $urandom; y = $urandom;
      @(posedge clk); #1;
    end
    out_ready = 1'b1; x = a2; y = b2; m = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL consume_no_accept got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; x = '0; y = '0; m = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL accept_after_idle got rdy=%b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({s, cout, of, zero, lat} !== {es2, ec2, eo2, ez2, 32'd4}) begin
      failures++;
      $display("FAIL second_result got s=%h c=%b o=%b z=%b lat=%0d want s=%h c=%b o=%b z=%b lat=4",
               s, cout, of, zero, lat, es2, ec2, eo2, ez2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop;
    int seen;
    logic [31:0] rs, es; logic rc, ro, rz, ec, eo, ez, acc; int lat;
    in_valid = 1'b1; x = 32'h1111_1111; y = 32'h2222_2222; m = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, s, cout, of, zero} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      failures++;
      $display("FAIL midop_reset got rdy=%b vld=%b s=%h c=%b o=%b z=%b want rdy=1 vld=0 s=0 flags=0",
               in_ready, out_valid, s, cout, of, zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL discarded_op got out_valid cycles=%0d want 0", seen);
    end
    model(32'hFFFF_0000, 32'h0001_0000, 1'b1, es, ec, eo, ez);
    run_op(32'hFFFF_0000, 32'h0001_0000, 1'b1, rs, rc, ro, rz, lat, acc);
    checks++;
    if ({acc, rs, rc, ro, rz, lat} !== {1'b1, es, ec, eo, ez, 32'd4}) begin
      failures++;
      $display("FAIL post_reset_op got acc=%b s=%h c=%b o=%b z=%b lat=%0d want acc=1 s=%h c=%b o=%b z=%b lat=4",
               acc, rs, rc, ro, rz, lat, es, ec, eo, ez);
    end
  endtask

  task automatic test_width16;
    logic [15:0] ta[2], tb[2], es[2];
    logic        tm[2], ec[2], eo[2];
    int lat;
    ta = '{16'h8000, 16'h7FFF};
    tb = '{16'h0001, 16'h0001};
    tm = '{1'b1, 1'b0};
`ifdef ADDSUB_SATURATE_EN
    es = '{16'h8000, 16'h7FFF};
`else
    es = '{16'h7FFF, 16'h8000};
`endif
    ec = '{1'b1, 1'b0};
    eo = '{1'b1, 1'b1};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (h_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL w16_ready_%0d got %b want 1", i, h_in_ready);
      end
      h_in_valid = 1'b1; h_x = ta[i]; h_y = tb[i]; h_m = tm[i];
      @(posedge clk); #1;
      h_in_valid = 1'b0; h_x = 16'($urandom); h_y = 16'($urandom);
      lat = 0;
      while (!h_out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if ({h_s, h_cout, h_of, h_zero, lat} !== {es[i], ec[i], eo[i], 1'b0, 32'd4}) begin
        failures++;
        $display("FAIL w16_%0d got s=%h c=%b o=%b z=%b lat=%0d want s=%h c=%b o=%b z=0 lat=4",
                 i, h_s, h_cout, h_of, h_zero, lat, es[i], ec[i], eo[i]);
      end
      h_out_ready = 1'b1;
      @(posedge clk); #1;
      h_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_midop;
    test_width16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
